// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin front end for a single-port BRAM.
// Owns every BRAM port, returns registered read data per requester and
// runs a zero-fill sweep of the whole array after reset or on command.
module bram_port_arbiter #(
    parameter int AW            = 10,
    parameter int DW            = 32,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    // requester 0
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    // requester 1
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    // clear engine
    input  logic          clr_start,
    output logic          init_busy,
    // BRAM side
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam state_t        RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_SERVE;
    localparam logic [AW-1:0] CNT_LAST    = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;          // sweep address
    logic          last_q, last_d;        // requester that won most recently
    logic [AW-1:0] addr_hold_q, addr_hold_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          gnt0_c, gnt1_c;
    logic          bram_we_c;
    logic [AW-1:0] bram_addr_c;
    logic [DW-1:0] bram_din_c;

    // Round-robin grant: on a tie the requester that did not win last goes.
    // Grants are qualified with rst_n so nothing is offered while in reset.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rst_n && state_q == ST_SERVE) begin
            if (req0 && (!req1 || last_q)) begin
                gnt0_c = 1'b1;
            end else if (req1) begin
                gnt1_c = 1'b1;
            end
        end
    end

    // BRAM drive: sweep address in INIT, otherwise the winner's access;
    // with no winner the address bus parks on its previous value.
    always_comb begin
        bram_we_c   = 1'b0;
        bram_addr_c = addr_hold_q;
        bram_din_c  = '0;
        if (state_q == ST_INIT) begin
            bram_we_c   = rst_n;
            bram_addr_c = cnt_q;
        end else if (gnt0_c) begin
            bram_we_c   = we0;
            bram_addr_c = addr0;
            bram_din_c  = wdata0;
        end else if (gnt1_c) begin
            bram_we_c   = we1;
            bram_addr_c = addr1;
            bram_din_c  = wdata1;
        end
    end

    // Next-state, sweep counter, fairness pointer and read-return capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        addr_hold_d = bram_addr_c;
        rvalid0_d   = gnt0_c && !we0;
        rvalid1_d   = gnt1_c && !we1;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        if (rvalid0_d) begin
            rdata0_d = bram_dout;
        end
        if (rvalid1_d) begin
            rdata1_d = bram_dout;
        end

        case (state_q)
            ST_INIT: begin
                // clr_start is deliberately ignored while sweeping
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SERVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SERVE: begin
                if (gnt0_c) begin
                    last_d = 1'b0;
                end else if (gnt1_c) begin
                    last_d = 1'b1;
                end
                // The access granted this cycle still completes at the edge.
                if (clr_start) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // State register; reset restarts the sweep from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            addr_hold_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values
            // from before the edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            addr_hold_q <= addr_hold_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign gnt0      = gnt0_c;
    assign gnt1      = gnt1_c;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign init_busy = (state_q == ST_INIT);
    assign bram_we   = bram_we_c;
    assign bram_addr = bram_addr_c;
    assign bram_din  = bram_din_c;

    // Grants are mutually exclusive by construction.
    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised bench for bram_port_arbiter with a transaction-level model:
// an array memory, a "who won last" integer and a sweep countdown.
module tb_bram_port_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          clr_start, init_busy;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    bram_port_arbiter #(.AW(AW), .DW(DW), .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .clr_start(clr_start), .init_busy(init_busy),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    // Attached BRAM: synchronous write, combinational read.
    logic [DW-1:0] bram_mem [DEPTH];
    always @(posedge clk) if (bram_we) bram_mem[bram_addr] <= bram_din;
    assign bram_dout = bram_mem[bram_addr];

    // ---------------- reference model state ----------------
    typedef struct {
        bit            v;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    acc_t          pend [2];
    logic [DW-1:0] ref_mem [DEPTH];
    int            init_left;
    int            last_winner;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] exp_rd [2];
    bit            clr_cmd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic post(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i].v    = 1'b1;
        pend[i].we   = we;
        pend[i].addr = a;
        pend[i].data = d;
    endtask

    // One clock cycle: drive held requests, check combinational outputs
    // against the model, advance the model, then check registered outputs.
    task automatic step();
        int   win;
        bit   rv_n [2];
        bit   do_clear;
        acc_t a;
        req0 = pend[0].v; we0 = pend[0].we; addr0 = pend[0].addr; wdata0 = pend[0].data;
        req1 = pend[1].v; we1 = pend[1].we; addr1 = pend[1].addr; wdata1 = pend[1].data;
        clr_start = clr_cmd;
        #1;
        win = -1;
        if (init_left > 0) begin
            check("init_busy_hi", init_busy, 1);
            check("init_gnt0", gnt0, 0);
            check("init_gnt1", gnt1, 0);
            check("init_we", bram_we, 1);
            check("init_addr", bram_addr, DEPTH - init_left);
            check("init_din", bram_din, 0);
        end else begin
            check("init_busy_lo", init_busy, 0);
            if (pend[0].v && pend[1].v) win = (last_winner == 1) ? 0 : 1;
            else if (pend[0].v) win = 0;
            else if (pend[1].v) win = 1;
            check("gnt0", gnt0, (win == 0));
            check("gnt1", gnt1, (win == 1));
            if (win >= 0) begin
                check("bram_we", bram_we, pend[win].we);
                check("bram_addr", bram_addr, pend[win].addr);
                if (pend[win].we) check("bram_din", bram_din, pend[win].data);
            end else begin
                check("idle_we", bram_we, 0);
                check("idle_addr_hold", bram_addr, prev_addr);
            end
        end

        rv_n = '{1'b0, 1'b0};
        do_clear = (init_left == 0) && clr_cmd;
        if (win >= 0) begin
            a = pend[win];
            prev_addr   = a.addr;
            last_winner = win;
            if (a.we) begin
                ref_mem[a.addr] = a.data;
            end else begin
                rv_n[win]   = 1'b1;
                exp_rd[win] = ref_mem[a.addr];
            end
            pend[win].v = 1'b0;
        end
        if (init_left > 0) begin
            prev_addr = AW'(DEPTH - init_left);
            init_left--;
        end
        if (do_clear) begin
            init_left = DEPTH;
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        end
        clr_cmd = 1'b0;

        @(posedge clk);
        #1;
        check("rvalid0", rvalid0, rv_n[0]);
        check("rvalid1", rvalid1, rv_n[1]);
        check("rdata0", rdata0, exp_rd[0]);
        check("rdata1", rdata1, exp_rd[1]);
    endtask

    task automatic drain();
        int n = 0;
        while ((pend[0].v || pend[1].v) && n < 2000) begin
            step();
            n++;
        end
        check("drain_timeout", (pend[0].v || pend[1].v), 0);
    endtask

    task automatic sweep_out();
        while (init_left > 0) step();
    endtask

    // Asynchronous reset: outputs must take reset values at once.
    task automatic do_reset();
        rst_n = 1'b0;
        pend[0].v = 1'b0; pend[1].v = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; clr_start = 0; clr_cmd = 0;
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_din", bram_din, 0);
        check("rst_init_busy", init_busy, 1);
        init_left   = DEPTH;
        last_winner = 1;
        prev_addr   = '0;
        exp_rd[0]   = '0;
        exp_rd[1]   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bram_mem[k] = $urandom;
            ref_mem[k]  = '0;
        end
        pend[0] = '{1'b0, 1'b0, '0, '0};
        pend[1] = '{1'b0, 1'b0, '0, '0};

        // Reset, then the full power-up sweep.
        do_reset();
        sweep_out();

        // Top word reads back zero after the sweep.
        post(0, 1'b0, 10'h3FF, '0);
        drain();

        // Write by 0, read of the same word by 1 on the next cycle.
        post(0, 1'b1, 10'h005, 32'hDEADBEEF);
        step();
        post(1, 1'b0, 10'h005, '0);
        drain();

        // Simultaneous writes to one word, then read it back.
        post(0, 1'b1, 10'h010, 32'h0000_1111);
        post(1, 1'b1, 10'h010, 32'h0000_2222);
        drain();
        post(0, 1'b0, 10'h010, '0);
        drain();

        // Both requesters hold reads continuously: grants must alternate.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i].v) post(i, 1'b0, AW'($urandom_range(0, 31)), '0);
            step();
        end
        drain();

        // Clear command alongside a write; requester 1 stalls across the sweep.
        post(0, 1'b1, 10'h020, 32'hA5A5A5A5);
        clr_cmd = 1'b1;
        step();
        post(1, 1'b0, 10'h020, '0);
        drain();
        post(0, 1'b0, 10'h020, '0);
        drain();

        // Reset asserted 500 cycles into a sweep; sweep restarts from 0.
        clr_cmd = 1'b1;
        step();
        repeat (500) step();
        do_reset();
        sweep_out();

        // Randomised traffic with occasional clear commands.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i].v && $urandom_range(0, 99) < 65) begin
                    post(i, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 15)),
                         $urandom);
                end
            end
            if ($urandom_range(0, 599) == 0) clr_cmd = 1'b1;
            step();
        end
        drain();
        sweep_out();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
